rf_cycle_scheduler: RTL and testbench

RF_CYCLE_SCHEDULER -- requirements
Module: rf_cycle_scheduler

---
 rtl/rf_cycle_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_rf_cycle_scheduler.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_cycle_scheduler.sv
// RF measurement cycle scheduler: DAC bring-up, break-before-make TX/RX path
// sequencing, transmit pulse generation and echo wait for initiator/responder modes.
module rf_cycle_scheduler #(
  parameter int unsigned GUARD_CYCLES   = 2,
  parameter int unsigned SETTLE_CYCLES  = 10,
  parameter int unsigned PULSE_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Start,
  input  logic i_Mode,
  input  logic i_RxData,
  input  logic i_DacReady,
  output logic o_DacStart,
  output logic o_TxPulse,
  output logic o_AntennaTransmitter,
  output logic o_EnableAmplifier,
  output logic o_AntennaReceiver,
  output logic o_EnableReceiverPower,
  output logic o_EnableLowNoiseAmplifier,
  output logic o_Done,
  output logic o_Timeout,
  output logic o_Busy
);

  localparam int unsigned CW = 16;

  // Last counter value of each timed state; a state with N cycles exits at N-1.
  localparam logic [CW-1:0] GUARD_LAST   = CW'(GUARD_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] PULSE_LAST   = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX      = {CW{1'b1}};

  typedef enum logic [3:0] {
    S_DAC_START,
    S_DAC_WAIT,
    S_IDLE,
    S_ARMED,
    S_GUARD_TX,
    S_TX_SETTLE,
    S_TX_PULSE,
    S_GUARD_RX,
    S_RX_WAIT,
    S_FINISH
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mode_q, mode_d;

  logic [1:0]    start_sync_q;
  logic          start_prev_q;
  logic [1:0]    rx_sync_q;
  logic          rx_prev_q;

  logic          start_rise_c;
  logic          rx_rise_c;
  logic          rx_fall_c;

  logic          dac_start_q, dac_start_d;
  logic          tx_pulse_q,  tx_pulse_d;
  logic          tx_en_q,     tx_en_d;
  logic          rx_en_q,     rx_en_d;
  logic          done_q,      done_d;
  logic          timeout_q,   timeout_d;
  logic          busy_q,      busy_d;

  // Two-stage synchronisers plus a delay stage for edge detection.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      start_sync_q <= '0;
      start_prev_q <= 1'b0;
      rx_sync_q    <= '0;
      rx_prev_q    <= 1'b0;
    end else begin
      start_sync_q <= {start_sync_q[0], i_Start};
      start_prev_q <= start_sync_q[1];
      rx_sync_q    <= {rx_sync_q[0], i_RxData};
      rx_prev_q    <= rx_sync_q[1];
    end
  end

  assign start_rise_c = start_sync_q[1] & ~start_prev_q;
  assign rx_rise_c    = rx_sync_q[1] & ~rx_prev_q;
  assign rx_fall_c    = ~rx_sync_q[1] & rx_prev_q;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= S_DAC_START;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  // Edges seen in states that do not consume them are simply dropped.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    timeout_d = 1'b0;
    unique case (state_q)
      S_DAC_START: state_d = S_DAC_WAIT;
      S_DAC_WAIT: begin
        if (i_DacReady) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (i_Mode && start_rise_c) begin
          state_d = S_GUARD_TX;
          mode_d  = 1'b1;
        end else if (!i_Mode && rx_rise_c) begin
          state_d = S_ARMED;
          mode_d  = 1'b0;
        end
      end
      S_ARMED: begin
        if (rx_fall_c) begin
          state_d = S_GUARD_TX;
        end else if (cnt_q >= TIMEOUT_LAST) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end
      end
      S_GUARD_TX: begin
        if (cnt_q >= GUARD_LAST) state_d = S_TX_SETTLE;
      end
      S_TX_SETTLE: begin
        if (cnt_q >= SETTLE_LAST) state_d = S_TX_PULSE;
      end
      S_TX_PULSE: begin
        if (cnt_q >= PULSE_LAST) state_d = S_GUARD_RX;
      end
      S_GUARD_RX: begin
        if (cnt_q >= GUARD_LAST) state_d = mode_q ? S_RX_WAIT : S_FINISH;
      end
      S_RX_WAIT: begin
        // A coincident echo edge takes priority over the timeout.
        if (rx_rise_c) begin
          state_d = S_FINISH;
        end else if (cnt_q >= TIMEOUT_LAST) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_DAC_START;
    endcase
  end

  // Per-state counter: restarts on every state change and saturates.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Output decode from the next state so the registered outputs track state_q.
  always_comb begin
    dac_start_d = (state_q == S_DAC_START);
    tx_en_d     = (state_d == S_TX_SETTLE) || (state_d == S_TX_PULSE);
    rx_en_d     = (state_d == S_IDLE) || (state_d == S_ARMED) ||
                  (state_d == S_RX_WAIT) || (state_d == S_FINISH);
    tx_pulse_d  = (state_d == S_TX_PULSE);
    done_d      = (state_d == S_FINISH);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      dac_start_q <= 1'b0;
      tx_pulse_q  <= 1'b0;
      tx_en_q     <= 1'b0;
      rx_en_q     <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      dac_start_q <= dac_start_d;
      tx_pulse_q  <= tx_pulse_d;
      tx_en_q     <= tx_en_d;
      rx_en_q     <= rx_en_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      busy_q      <= busy_d;
    end
  end

  assign o_DacStart                = dac_start_q;
  assign o_TxPulse                 = tx_pulse_q;
  assign o_AntennaTransmitter      = tx_en_q;
  assign o_EnableAmplifier         = tx_en_q;
  assign o_AntennaReceiver         = rx_en_q;
  assign o_EnableReceiverPower     = rx_en_q;
  assign o_EnableLowNoiseAmplifier = rx_en_q;
  assign o_Done                    = done_q;
  assign o_Timeout                 = timeout_q;
  assign o_Busy                    = busy_q;

endmodule

// File: tb/tb_rf_cycle_scheduler.sv
// Directed bench for rf_cycle_scheduler with GUARD=2, SETTLE=5, PULSE=4, TIMEOUT=100.
module tb_rf_cycle_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic mode = 1'b1;
  logic rxd = 1'b0;
  logic dac_ready = 1'b0;

  logic dac_start, tx_pulse, ant_tx, amp, ant_rx, rx_pwr, lna, done, timeout, busy;

  int checks = 0;
  int errors = 0;

  rf_cycle_scheduler #(
    .GUARD_CYCLES(2), .SETTLE_CYCLES(5), .PULSE_CYCLES(4), .TIMEOUT_CYCLES(100)
  ) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Start(start), .i_Mode(mode),
    .i_RxData(rxd), .i_DacReady(dac_ready),
    .o_DacStart(dac_start), .o_TxPulse(tx_pulse),
    .o_AntennaTransmitter(ant_tx), .o_EnableAmplifier(amp),
    .o_AntennaReceiver(ant_rx), .o_EnableReceiverPower(rx_pwr),
    .o_EnableLowNoiseAmplifier(lna),
    .o_Done(done), .o_Timeout(timeout), .o_Busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] outs();
    return {dac_start, tx_pulse, ant_tx, amp, ant_rx, rx_pwr, lna, done, timeout, busy};
  endfunction

  // Raise i_Start and return the cycles until o_Busy rises (bounded).
  task automatic kick_start(output int lat);
    start = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!busy && lat < 10);
    start = 1'b0;
  endtask

  // Checks cycles 0..13 from GUARD_TX entry (cycle 0 already sampled by caller).
  task automatic run_sequence(input bit responder, input bit toggle_start, input int flip_mode_at);
    logic [9:0] exp_v;
    bit e_tx, e_pulse, e_rx, e_done;
    for (int i = 0; i <= 13; i++) begin
      if (i > 0) tick();
      e_tx    = (i >= 2 && i <= 10);
      e_pulse = (i >= 7 && i <= 10);
      e_rx    = (i == 13);
      e_done  = (i == 13) && responder;
      exp_v   = {1'b0, e_pulse, e_tx, e_tx, e_rx, e_rx, e_rx, e_done, 1'b0, 1'b1};
      checks++;
      if (outs() !== exp_v) begin
        errors++;
        $display("FAIL seq_cycle%0d: got %b expected %b", i, outs(), exp_v);
      end
      if (toggle_start) start = ~start;
      if (i == flip_mode_at) mode = ~mode;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (outs() !== 10'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", outs(), 10'b0);
    end
  endtask

  task automatic test_dac_init();
    int strobes = 0;
    int first = -1;
    dac_ready = 1'b0;
    rst_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (dac_start) begin
        strobes++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (strobes != 1 || first != 1) begin
      errors++;
      $display("FAIL dac_strobe: got count %0d at %0d expected count 1 at 1", strobes, first);
    end
    checks++;
    if ({busy, ant_tx, amp, ant_rx, rx_pwr, lna} !== 6'b100000) begin
      errors++;
      $display("FAIL dac_wait_outs: got %b expected 100000",
               {busy, ant_tx, amp, ant_rx, rx_pwr, lna});
    end
    dac_ready = 1'b1;
    tick();
    dac_ready = 1'b0;
    checks++;
    if ({busy, ant_rx, rx_pwr, lna, ant_tx} !== 5'b01110) begin
      errors++;
      $display("FAIL dac_to_idle: got %b expected 01110", {busy, ant_rx, rx_pwr, lna, ant_tx});
    end
  endtask

  task automatic test_initiator_echo();
    int lat, dn, to, first;
    mode = 1'b1;
    tick();
    kick_start(lat);
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL init_start_latency: got %0d expected 3", lat);
    end
    run_sequence(1'b0, 1'b0, -1);
    repeat (30) tick();
    rxd = 1'b1;
    dn = 0; to = 0; first = -1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (done) begin
        dn++;
        if (first < 0) first = k;
      end
      if (timeout) to++;
    end
    rxd = 1'b0;
    checks++;
    if (dn != 1 || first != 3 || to != 0) begin
      errors++;
      $display("FAIL init_echo_done: got done %0d at %0d timeout %0d expected 1 at 3 timeout 0",
               dn, first, to);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL init_echo_idle: got busy %b expected 0", busy);
    end
    repeat (4) tick();
  endtask

  task automatic test_initiator_timeout();
    int lat, dn, to, first;
    mode = 1'b1;
    kick_start(lat);
    run_sequence(1'b0, 1'b0, -1);
    dn = 0; to = 0; first = -1;
    for (int k = 1; k <= 110; k++) begin
      tick();
      if (done) dn++;
      if (timeout) begin
        to++;
        if (first < 0) first = k;
      end
    end
    checks++;
    if (to != 1 || first != 100 || dn != 0) begin
      errors++;
      $display("FAIL rx_wait_timeout: got timeout %0d at %0d done %0d expected 1 at 100 done 0",
               to, first, dn);
    end
    checks++;
    if ({busy, ant_rx} !== 2'b01) begin
      errors++;
      $display("FAIL rx_timeout_idle: got busy/rx %b expected 01", {busy, ant_rx});
    end
  endtask

  task automatic test_responder();
    int first, lat;
    bit any_busy;
    mode = 1'b0;
    tick();
    any_busy = 1'b0;
    start = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 5) start = 1'b0;
      if (busy) any_busy = 1'b1;
    end
    checks++;
    if (any_busy) begin
      errors++;
      $display("FAIL resp_start_ignored: got busy 1 expected 0");
    end
    rxd = 1'b1;
    first = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (busy && first < 0) first = i;
    end
    checks++;
    if (first != 3 || {ant_rx, ant_tx} !== 2'b10) begin
      errors++;
      $display("FAIL resp_armed: got busy at %0d rx/tx %b expected 3 and 10", first, {ant_rx, ant_tx});
    end
    rxd = 1'b0;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (ant_rx && lat < 10);
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL resp_fall_latency: got %0d expected 3", lat);
    end
    run_sequence(1'b1, 1'b1, -1);
    tick();
    checks++;
    if ({busy, done, timeout} !== 3'b000) begin
      errors++;
      $display("FAIL resp_back_idle: got %b expected 000", {busy, done, timeout});
    end
    repeat (4) tick();
  endtask

  task automatic test_armed_timeout();
    int to, first;
    bit any_busy;
    mode = 1'b0;
    rxd = 1'b1;
    repeat (3) tick();
    to = 0; first = -1;
    for (int k = 1; k <= 105; k++) begin
      tick();
      if (timeout) begin
        to++;
        if (first < 0) first = k;
      end
    end
    checks++;
    if (to != 1 || first != 100 || busy !== 1'b0) begin
      errors++;
      $display("FAIL armed_timeout: got %0d at %0d busy %b expected 1 at 100 busy 0", to, first, busy);
    end
    rxd = 1'b0;
    any_busy = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (busy) any_busy = 1'b1;
    end
    checks++;
    if (any_busy) begin
      errors++;
      $display("FAIL idle_fall_ignored: got busy 1 expected 0");
    end
  endtask

  task automatic test_mode_toggle();
    int lat;
    mode = 1'b1;
    tick();
    kick_start(lat);
    run_sequence(1'b0, 1'b0, 3);
    mode = 1'b1;
    rxd = 1'b1;
    repeat (3) tick();
    checks++;
    if ({done, busy} !== 2'b11) begin
      errors++;
      $display("FAIL mode_latched_done: got done/busy %b expected 11", {done, busy});
    end
    rxd = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset_during_pulse();
    int lat, strobes, first;
    mode = 1'b1;
    kick_start(lat);
    repeat (8) tick();
    checks++;
    if (tx_pulse !== 1'b1) begin
      errors++;
      $display("FAIL pulse_before_reset: got %b expected 1", tx_pulse);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs() !== 10'b0) begin
      errors++;
      $display("FAIL async_reset_outs: got %b expected %b", outs(), 10'b0);
    end
    dac_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    strobes = 0; first = -1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (dac_start) begin
        strobes++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (strobes != 1 || first != 1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rerun_dac: got count %0d at %0d busy %b expected 1 at 1 busy 1",
               strobes, first, busy);
    end
    dac_ready = 1'b1;
    tick();
    dac_ready = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rerun_dac_idle: got busy %b expected 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_dac_init();
    test_initiator_echo();
    test_initiator_timeout();
    test_responder();
    test_armed_timeout();
    test_mode_toggle();
    test_reset_during_pulse();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
